// File: rtl/pwm_multi_ch_if.sv
// Bus bundle for pwm_multi_ch: run/mode controls, duty shadow writes and the PWM outputs.
// master = controller side, slave = the PWM block.
interface pwm_multi_ch_if #(
  parameter int pWIDTH = 10,
  parameter int pCH    = 4
);
  logic                    en;
  logic                    mode;
  logic [pCH-1:0]          duty_wr;
  logic [pCH*pWIDTH-1:0]   cyc_duty;
  logic [pCH-1:0]          wave;
  logic [pCH-1:0]          wave_n;
  logic                    end_tick;

  modport master (output en, mode, duty_wr, cyc_duty, input  wave, wave_n, end_tick);
  modport slave  (input  en, mode, duty_wr, cyc_duty, output wave, wave_n, end_tick);
endinterface

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared edge/center-aligned counter, per-channel double-buffered duty.
// Optional dead-time insertion on the complementary outputs when PWM_DEADTIME_EN is defined.
module pwm_multi_ch_lane #(
  parameter int pWIDTH = 10
`ifdef PWM_DEADTIME_EN
  , parameter int pDEAD = 2
`endif
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_wr,
  input  logic              i_load,
  input  logic [pWIDTH-1:0] i_duty,
  input  logic [pWIDTH-1:0] i_cnt,
  output logic              o_wave,
  output logic              o_wave_n
);
  logic [pWIDTH-1:0] r_shadow, r_active;
  logic              r_wave, r_wave_n;
  logic              w_raw;

  // active takes the pre-write shadow when a write lands on a load edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (i_wr)   r_shadow <= i_duty;
      if (i_load) r_active <= r_shadow;
    end
  end

  assign w_raw = (i_cnt < r_active);

`ifdef PWM_DEADTIME_EN
  localparam int              cDW   = (pDEAD < 2) ? 1 : $clog2(pDEAD + 1);
  localparam logic [cDW-1:0]  cDEAD = cDW'(pDEAD);
  localparam logic [cDW-1:0]  cONE  = cDW'(1);

  logic           r_raw;
  logic [cDW-1:0] r_dcnt;

  // any raw edge blanks both outputs and (re)starts the dead-time window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw    <= 1'b0;
      r_dcnt   <= '0;
      r_wave   <= 1'b0;
      r_wave_n <= 1'b0;
    end else if (!i_en) begin
      r_raw    <= 1'b0;
      r_dcnt   <= '0;
      r_wave   <= 1'b0;
      r_wave_n <= 1'b0;
    end else begin
      r_raw <= w_raw;
      if (w_raw != r_raw) begin
        r_dcnt   <= cDEAD;
        r_wave   <= 1'b0;
        r_wave_n <= 1'b0;
      end else if (r_dcnt > cONE) begin
        r_dcnt <= r_dcnt - cONE;
      end else begin
        r_dcnt   <= '0;
        r_wave   <= w_raw;
        r_wave_n <= ~w_raw;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wave   <= 1'b0;
      r_wave_n <= 1'b0;
    end else begin
      r_wave   <= i_en & w_raw;
      r_wave_n <= i_en & ~w_raw;
    end
  end
`endif

  assign o_wave   = r_wave;
  assign o_wave_n = r_wave_n;
endmodule

module pwm_multi_ch #(
  parameter int pWIDTH  = 10,
  parameter int pCH     = 4,
  parameter int pPERIOD = 210,
  parameter int pINC    = 5,
  parameter int pDEAD   = 2
)(
  input logic          clk,
  input logic          rst_n,
  pwm_multi_ch_if.slave bus
);
  localparam logic [pWIDTH:0] cINC = (pWIDTH+1)'(pINC);
  localparam logic [pWIDTH:0] cPER = (pWIDTH+1)'(pPERIOD);

  typedef enum logic {ST_UP = 1'b0, ST_DOWN = 1'b1} dir_t;

  dir_t              r_dir, w_dir_nxt;
  logic [pWIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [pWIDTH:0]   w_up_sum;
  logic              r_mode_act, r_end_tick, w_last_nxt, w_load;
  logic [pCH-1:0]    w_wave, w_wave_n;

  assign w_up_sum = {1'b0, r_cnt} + cINC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_dir <= ST_UP;
    else if (!bus.en) r_dir <= ST_UP;
    else              r_dir <= w_dir_nxt;
  end

  // center mode turns around at the last up state instead of wrapping
  always_comb begin
    w_dir_nxt = r_dir;
    case (r_dir)
      ST_UP:   if (r_mode_act && (w_up_sum >= cPER) && ({1'b0, r_cnt} > cINC)) w_dir_nxt = ST_DOWN;
      ST_DOWN: if ({1'b0, r_cnt} <= cINC) w_dir_nxt = ST_UP;
      default: w_dir_nxt = ST_UP;
    endcase
  end

  always_comb begin
    w_cnt_nxt = '0;
    case (r_dir)
      ST_UP: begin
        if (w_up_sum < cPER)          w_cnt_nxt = w_up_sum[pWIDTH-1:0];
        else if (w_dir_nxt == ST_DOWN) w_cnt_nxt = r_cnt - cINC[pWIDTH-1:0];
      end
      ST_DOWN: if ({1'b0, r_cnt} > cINC) w_cnt_nxt = r_cnt - cINC[pWIDTH-1:0];
      default: w_cnt_nxt = '0;
    endcase
    // next cnt = 0 is never final, so the pre-boundary mode is safe to use here
    w_last_nxt = r_mode_act ? ((w_dir_nxt == ST_DOWN) && ({1'b0, w_cnt_nxt} == cINC))
                            : (({1'b0, w_cnt_nxt} + cINC) >= cPER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_mode_act <= 1'b0;
      r_end_tick <= 1'b0;
    end else if (!bus.en) begin
      r_cnt      <= '0;
      r_mode_act <= bus.mode;
      r_end_tick <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_end_tick <= w_last_nxt;
      if (r_end_tick) r_mode_act <= bus.mode;
    end
  end

  assign w_load = ~bus.en | r_end_tick;

  for (genvar gi = 0; gi < pCH; gi++) begin : g_ch
    pwm_multi_ch_lane #(
      .pWIDTH (pWIDTH)
`ifdef PWM_DEADTIME_EN
      , .pDEAD (pDEAD)
`endif
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (bus.en),
      .i_wr     (bus.duty_wr[gi]),
      .i_load   (w_load),
      .i_duty   (bus.cyc_duty[gi*pWIDTH +: pWIDTH]),
      .i_cnt    (r_cnt),
      .o_wave   (w_wave[gi]),
      .o_wave_n (w_wave_n[gi])
    );
  end

`ifndef PWM_DEADTIME_EN
  // dead-time length has no effect without the dead-time stage
  if (pDEAD < 0) begin : g_dead_unused
  end
`endif

  assign bus.wave     = w_wave;
  assign bus.wave_n   = w_wave_n;
  assign bus.end_tick = r_end_tick;
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: period-position reference model, duty/period table, corner sequences, random run.
module tb_pwm_multi_ch;
  localparam int W = 10, CH = 4, PER = 210, INC = 5, DEAD = 2;
  localparam int NUP = (PER - 1) / INC + 1;
`ifdef PWM_DEADTIME_EN
  localparam int DHI = DEAD;
`else
  localparam int DHI = 0;
`endif
  localparam logic [CH-1:0] RESTART_MASK = (DHI == 0) ? 4'b1101 : 4'b0000;

  typedef struct packed {
    logic                  mode;
    logic [CH-1:0][W-1:0]  duty;
    logic [CH-1:0][7:0]    hi;
    logic [7:0]            per;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0, n_fail = 0;

  pwm_multi_ch_if #(.pWIDTH(W), .pCH(CH)) bus ();
  pwm_multi_ch #(.pWIDTH(W), .pCH(CH), .pPERIOD(PER), .pINC(INC), .pDEAD(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // reference: position k within the period, cnt derived arithmetically
  int            m_k;
  logic          m_mode;
  logic [W-1:0]  m_sh  [CH];
  logic [W-1:0]  m_act [CH];
  logic [CH-1:0] e_wave, e_wave_n;
  logic          e_end;
`ifdef PWM_DEADTIME_EN
  logic [CH-1:0] m_prev;
  int            m_run [CH];
`endif
  int            ms_len;
  int            ms_hi [CH];
  vec_t          tbl[$];

  function automatic int per_of(logic m);
    return m ? 2 * (NUP - 1) : NUP;
  endfunction

  function automatic int cnt_of(int k, logic m);
    if (!m || k < NUP) return k * INC;
    return (per_of(m) - k) * INC;
  endfunction

  function automatic vec_t mk(logic m, int d0, int d1, int d2, int d3,
                              int h0, int h1, int h2, int h3, int p);
    vec_t v;
    v.mode = m;
    v.duty[0] = W'(d0); v.duty[1] = W'(d1); v.duty[2] = W'(d2); v.duty[3] = W'(d3);
    v.hi[0] = 8'(h0);   v.hi[1] = 8'(h1);   v.hi[2] = 8'(h2);   v.hi[3] = 8'(h3);
    v.per = 8'(p);
    return v;
  endfunction

  task automatic model_reset();
    m_k = 0; m_mode = 1'b0; e_wave = '0; e_wave_n = '0; e_end = 1'b0;
    for (int i = 0; i < CH; i++) begin m_sh[i] = '0; m_act[i] = '0; end
`ifdef PWM_DEADTIME_EN
    m_prev = '0;
    for (int i = 0; i < CH; i++) m_run[i] = DEAD + 1;
`endif
  endtask

  task automatic model_edge();
    logic [W-1:0] sh_old [CH];
    int c;
    logic raw;
    sh_old = m_sh;
    for (int i = 0; i < CH; i++) if (bus.duty_wr[i]) m_sh[i] = bus.cyc_duty[i*W +: W];
    if (!bus.en) begin
      m_k = 0; m_mode = bus.mode; m_act = sh_old;
      e_wave = '0; e_wave_n = '0; e_end = 1'b0;
`ifdef PWM_DEADTIME_EN
      m_prev = '0;
      for (int i = 0; i < CH; i++) m_run[i] = DEAD + 1;
`endif
    end else begin
      c = cnt_of(m_k, m_mode);
      for (int i = 0; i < CH; i++) begin
        raw = (c < int'(m_act[i]));
`ifdef PWM_DEADTIME_EN
        if (raw == m_prev[i]) m_run[i] = (m_run[i] > DEAD) ? DEAD + 1 : m_run[i] + 1;
        else                  m_run[i] = 1;
        m_prev[i]   = raw;
        e_wave[i]   = (m_run[i] > DEAD) & raw;
        e_wave_n[i] = (m_run[i] > DEAD) & ~raw;
`else
        e_wave[i]   = raw;
        e_wave_n[i] = ~raw;
`endif
      end
      if (m_k == per_of(m_mode) - 1) begin
        m_k = 0; m_act = sh_old; m_mode = bus.mode;
      end else begin
        m_k++;
      end
      e_end = (m_k == per_of(m_mode) - 1);
    end
  endtask

  task automatic check_cycle(string nm);
    n_tests++;
    if (bus.wave !== e_wave || bus.wave_n !== e_wave_n || bus.end_tick !== e_end) begin
      n_fail++;
      $display("FAIL %s t=%0t wave=%b want %b wave_n=%b want %b end_tick=%b want %b",
               nm, $time, bus.wave, e_wave, bus.wave_n, e_wave_n, bus.end_tick, e_end);
    end
  endtask

  task automatic expect_eq(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
    check_cycle("cycle");
  endtask

  task automatic wait_end(string nm);
    int n = 0;
    do begin tick(); n++; end while (!bus.end_tick && n < 200);
    if (!bus.end_tick) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no end_tick within 200 cycles", nm);
    end
  endtask

  // counts one period's cycles and wave highs, starting on an end_tick cycle
  task automatic measure();
    ms_len = 0;
    for (int i = 0; i < CH; i++) ms_hi[i] = 0;
    do begin
      tick();
      bus.duty_wr = '0;
      ms_len++;
      for (int i = 0; i < CH; i++) ms_hi[i] += int'(bus.wave[i]);
    end while (!bus.end_tick && ms_len < 200);
  endtask

  initial begin
    int n;
`ifdef PWM_DEADTIME_EN
    tbl.push_back(mk(1'b0, 100, 10, 0, 210, 18, 0, 0, 42, 42));
    tbl.push_back(mk(1'b1, 100, 10, 0, 210, 37, 1, 0, 82, 82));
`else
    tbl.push_back(mk(1'b0, 100, 100, 100, 100, 20, 20, 20, 20, 42));
    tbl.push_back(mk(1'b1, 100, 100, 100, 100, 39, 39, 39, 39, 82));
    tbl.push_back(mk(1'b0, 0, 210, 1023, 60,    0, 42, 42, 12, 42));
    tbl.push_back(mk(1'b1, 0, 210, 1023, 60,    0, 82, 82, 23, 82));
    tbl.push_back(mk(1'b0, 7, 5, 6, 205,        2, 1, 2, 41, 42));
    tbl.push_back(mk(1'b1, 7, 5, 206, 1,        3, 1, 82, 1, 82));
`endif
    bus.en = 1'b0; bus.mode = 1'b0; bus.duty_wr = '0; bus.cyc_duty = '0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_cycle("reset_state");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    bus.en = 1'b1;
    for (int r = 0; r < tbl.size(); r++) begin
      bus.mode = tbl[r].mode; bus.cyc_duty = tbl[r].duty; bus.duty_wr = '1;
      tick();
      bus.duty_wr = '0;
      wait_end("settle_a"); wait_end("settle_b");
      measure();
      expect_eq($sformatf("period_row%0d", r), ms_len, int'(tbl[r].per));
      for (int i = 0; i < CH; i++)
        expect_eq($sformatf("high_row%0d_ch%0d", r, i), ms_hi[i], int'(tbl[r].hi[i]));
    end

    // duty write colliding with the boundary edge
    bus.mode = 1'b0; bus.cyc_duty = {CH{10'd100}}; bus.duty_wr = '1;
    tick();
    bus.duty_wr = '0;
    wait_end("coll_a"); wait_end("coll_b");
    bus.duty_wr = 4'b1000; bus.cyc_duty[3*W +: W] = 10'd60;
    measure();
    expect_eq("collision_p1_ch3", ms_hi[3], 20 - DHI);
    measure();
    expect_eq("collision_p2_ch3", ms_hi[3], 12 - DHI);
    expect_eq("collision_p2_ch0", ms_hi[0], 20 - DHI);

    // async reset in the middle of a period, then en toggle
    n = 0;
    while (!(m_mode == 1'b0 && cnt_of(m_k, m_mode) == 120) && n < 200) begin tick(); n++; end
    if (n >= 200) begin n_tests++; n_fail++; $display("FAIL reach_cnt120: not reached"); end
    rst_n = 1'b0;
    model_reset();
    #1;
    check_cycle("async_reset");
    expect_eq("reset_outputs", int'({bus.wave, bus.wave_n, bus.end_tick}), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    bus.en = 1'b0;
    bus.cyc_duty[0*W +: W] = 10'd30;  bus.cyc_duty[1*W +: W] = 10'd0;
    bus.cyc_duty[2*W +: W] = 10'd210; bus.cyc_duty[3*W +: W] = 10'd1000;
    bus.duty_wr = '1;
    tick();
    bus.duty_wr = '0;
    tick(); tick();
    expect_eq("en_low_wave", int'({bus.wave, bus.wave_n}), 0);
    bus.en = 1'b1;
    tick();
    expect_eq("restart_wave", int'(bus.wave), int'(RESTART_MASK));
    n = 1;
    while (!bus.end_tick && n < 200) begin tick(); n++; end
    expect_eq("restart_first_period", n, NUP - 1);

    // random traffic against the model
    for (int t = 0; t < 3000; t++) begin
      int d;
      bus.duty_wr = '0;
      if ($urandom_range(3) == 0) begin
        for (int i = 0; i < CH; i++) begin
          bus.duty_wr[i] = 1'($urandom_range(1));
          case ($urandom_range(3))
            0:       d = 0;
            1:       d = PER;
            2:       d = int'($urandom_range(1023));
            default: d = int'($urandom_range(PER));
          endcase
          bus.cyc_duty[i*W +: W] = W'(d);
        end
      end
      if ($urandom_range(59) == 0)  bus.mode = ~bus.mode;
      if ($urandom_range(199) == 0) bus.en = ~bus.en;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
- Multi-channel PWM generator and successor to the single-channel PWM block.
- pCH channels share one period counter. Each channel has its own double-buffered duty register.
- Supports edge-aligned or center-aligned counting, selected at runtime.
- Drives complementary output pairs, for example to modulate per-channel waveforms from sample tables updated on end_tick.

Parameters:
- pWIDTH, 10, width of counter, duty and period values; must satisfy pPERIOD+pINC < 2^pWIDTH.
- pCH, 4, number of channels (>=1).
- pPERIOD, 210, period span; edge-aligned counter wraps before reaching it.
- pINC, 5, counter step per enabled clk (>=1).
- pDEAD, 2, dead-time in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period boundary.
- duty_wr  in  pCH  per-channel shadow write strobe.
- cyc_duty  in  pCH*pWIDTH  packed duty values; channel i is bits [i*pWIDTH +: pWIDTH].
- wave  out  pCH  high-side PWM outputs.
- wave_n  out  pCH  complementary outputs.
- end_tick  out  1  one-clk pulse on the last count of each period.

Behaviour:
- Reset (async, rst_n=0):
  - cnt=0, dir=up, mode_act=0.
  - All shadow and active duty registers = 0.
  - wave=0, wave_n=0, end_tick=0, dead-time counters=0.
  - Reset mid-period aborts the period immediately; no partial end_tick.
- Shadow write:
  - At a clk edge with duty_wr[i]=1, shadow[i] <= cyc_duty slice i.
  - Other channels are unaffected.
- en=0:
  - cnt held at 0, dir=up, end_tick=0, wave=0, wave_n=0.
  - Each clk: active[i] <= shadow[i] and mode_act <= mode, so restart uses the latest values.
  - Restart after en 0->1 begins at cnt=0.
- Edge-aligned (mode_act=0):
  - cnt steps by pINC while cnt+pINC < pPERIOD, else wraps to 0.
  - The sum is computed pWIDTH+1 bits wide; no overflow.
  - Last state = largest multiple of pINC below pPERIOD.
  - Period length = ceil(pPERIOD/pINC) clks.
- Center-aligned (mode_act=1):
  - Counts up as in edge mode to the last state L, then down by pINC to pINC, then returns to 0.
  - Period length = 2*(L/pINC) clks.
- end_tick (both modes):
  - Registered; high for exactly the clk in which cnt holds the period's final state.
  - At that edge: active[i] <= shadow[i] for all i, and mode_act <= mode.
- Update collision: if duty_wr coincides with the boundary edge, active receives the pre-write shadow value. The new value takes effect one period later.
- Raw output:
  - raw[i] = (cnt < active[i]), registered into wave/wave_n, so outputs lag cnt by 1 clk.
  - active >= pPERIOD gives constant high; active = 0 gives constant low.
  - No glitches at the period boundary.
- Default outputs (macro off): wave[i]=raw[i] and wave_n[i]=~raw[i] while en=1.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- Defined:
  - On any raw[i] transition, wave[i] and wave_n[i] both go 0 at the same edge.
  - A per-channel counter then runs for pDEAD clks; afterwards the output matching raw[i] asserts.
  - A raw toggle during dead-time restarts the counter.
  - Pulses of pDEAD clks or shorter never appear on either output.
  - wave and wave_n are never simultaneously 1.
- Undefined: no dead-time logic; wave_n = ~wave while en=1; pDEAD is ignored.

Test Plan:
- Default params, mode=0, en=1, write duty 100 to all channels, wait one boundary -> end_tick every 42 clks; wave high 20 clks, low 22 per period; wave_n inverse.
- mode=1 (applied at boundary), duty 100 -> period 82 clks; wave high 39 consecutive clks (cnt 0..95 up, 95..5 down); end_tick at cnt=5 descending.
- Ch0 duty=0, ch1 duty=210, ch2 duty=1023 -> ch0 always low; ch1 and ch2 always high; no pulse at any boundary.
- duty_wr[3]=1 with 60 on the end_tick cycle, previous shadow 100 -> next period ch3 high 20 clks, following period high 12 clks.
- Assert rst_n=0 mid-period with cnt=120, release, then en 1->0->1 -> all outputs 0 immediately; after restart, cnt starts at 0 with shadow values active.
- PWM_DEADTIME_EN, pDEAD=2, duty 100, edge mode -> wave high 18 clks; both outputs low for 2 clks at each transition; wave&wave_n never 1. Duty 10 gives wave high 0 clks.
